hazard_ctrl: RTL and testbench

Pipeline hazard sequencer for the 5-stage rv32i core. It decides every cycle which pipeline registers load, stall, flush or take a bubble, in response to load-use hazards, instruction/data memory stalls and EX-stage branch redirects. Its EX bubble is the all-zero control word that the forwarding unit treats as a load stall. It also keeps stall and flush performance counters.

---
 rtl/rv32i_types.sv | 14 +
 rtl/hazard_ctrl_sat_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i core types: register index, opcodes and hazard sequencer states.
package rv32i_types;

   typedef logic [4:0] rv32i_reg;

   localparam logic [6:0] op_load = 7'b0000011;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: per-cycle load/stall/flush/bubble decisions
// for load-use, memory stalls and EX redirects, plus perf counters.
module hazard_ctrl
   import rv32i_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  rv32i_reg         id_rs1,
   input  rv32i_reg         id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  rv32i_reg         ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_br_redirect,
   input  logic             imem_read,
   input  logic             imem_resp,
   input  logic             dmem_access,
   input  logic             dmem_resp,
   output logic             load_pc,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             bubble_id_ex,
   output logic             flush_if_id,
   output logic             pc_sel_redirect,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   hz_state_t state_q, state_d;
   logic      pend_q, pend_d;
   logic      mem_wait;
   logic      load_use;
   logic      redir;
   logic      lu_stall;

   assign mem_wait = (imem_read && !imem_resp) ||
                     (dmem_access && !dmem_resp);

   assign load_use = ex_is_load && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   assign redir = ex_br_redirect ||
                  ((state_q == MEM_WAIT) && pend_q);

   // The bubbled load never stalls twice, even if EX still reports it.
   assign lu_stall = load_use && (state_q != LOAD_STALL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = RUN;
      pend_d  = 1'b0;
      if (mem_wait) begin
         state_d = MEM_WAIT;
         pend_d  = pend_q || ex_br_redirect;
      end else if (!redir && lu_stall) begin
         state_d = LOAD_STALL;
      end
   end

   always_comb begin
      load_pc         = 1'b0;
      load_if_id      = 1'b0;
      load_id_ex      = 1'b0;
      load_ex_mem     = 1'b0;
      load_mem_wb     = 1'b0;
      bubble_id_ex    = 1'b0;
      flush_if_id     = 1'b0;
      pc_sel_redirect = 1'b0;
      priority case (1'b1)
         rst, mem_wait: ;
         redir: begin
            load_pc         = 1'b1;
            load_if_id      = 1'b1;
            load_id_ex      = 1'b1;
            load_ex_mem     = 1'b1;
            load_mem_wb     = 1'b1;
            bubble_id_ex    = 1'b1;
            flush_if_id     = 1'b1;
            pc_sel_redirect = 1'b1;
         end
         lu_stall: begin
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            bubble_id_ex = 1'b1;
         end
         default: begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!load_pc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pc_sel_redirect),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; narrow counters expose saturation.
module tb_hazard_ctrl;

   localparam int W = 5;
   localparam logic [W-1:0] MAXC = '1;

   // {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush, pcsel}
   localparam logic [7:0] NORM = 8'b11111_000;
   localparam logic [7:0] FRZ  = 8'b00000_000;
   localparam logic [7:0] LU   = 8'b00111_100;
   localparam logic [7:0] RD   = 8'b11111_111;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_is_load, ex_br_redirect;
   logic imem_read, imem_resp, dmem_access, dmem_resp;
   logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic bubble_id_ex, flush_if_id, pc_sel_redirect;
   logic [W-1:0] stall_cycles, flush_count;

   typedef struct {
      logic [7:0] ctl;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int nvec = 0;
   int nerr = 0;
   logic [W-1:0] m_stall, m_flush;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .ex_br_redirect(ex_br_redirect),
      .imem_read(imem_read), .imem_resp(imem_resp),
      .dmem_access(dmem_access), .dmem_resp(dmem_resp),
      .load_pc(load_pc), .load_if_id(load_if_id),
      .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
      .load_mem_wb(load_mem_wb), .bubble_id_ex(bubble_id_ex),
      .flush_if_id(flush_if_id), .pc_sel_redirect(pc_sel_redirect),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   function automatic logic [7:0] ctl();
      return {load_pc, load_if_id, load_id_ex, load_ex_mem,
              load_mem_wb, bubble_id_ex, flush_if_id, pc_sel_redirect};
   endfunction

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
      ex_br_redirect = 0;
      imem_read = 0; imem_resp = 0;
      dmem_access = 0; dmem_resp = 0;
   endtask

   // Called at a negedge with inputs already driven.
   task automatic cyc(input logic [7:0] e, input string nm);
      exp_t x;
      sb.push_back('{e, nm});
      if (!e[7] && m_stall != MAXC) m_stall = m_stall + 1'b1;
      if (e[0] && m_flush != MAXC) m_flush = m_flush + 1'b1;
      #1;
      x = sb.pop_front();
      nvec++;
      if (ctl() !== x.ctl) begin
         nerr++;
         $display("FAIL %s ctl got %b want %b", x.nm, ctl(), x.ctl);
      end
      @(posedge clk); #1;
      nvec++;
      if (stall_cycles !== m_stall) begin
         nerr++;
         $display("FAIL %s stall_cycles got %0d want %0d",
                  x.nm, stall_cycles, m_stall);
      end
      nvec++;
      if (flush_count !== m_flush) begin
         nerr++;
         $display("FAIL %s flush_count got %0d want %0d",
                  x.nm, flush_count, m_flush);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      m_stall = '0;
      m_flush = '0;
      repeat (2) @(negedge clk);
      #1;
      nvec++;
      if (ctl() !== 8'h00) begin
         nerr++;
         $display("FAIL reset_ctl got %b want %b", ctl(), 8'h00);
      end
      nvec++;
      if ({stall_cycles, flush_count} !== '0) begin
         nerr++;
         $display("FAIL reset_cnt got %0d/%0d want 0/0",
                  stall_cycles, flush_count);
      end
      @(negedge clk);
      rst = 1'b0;
      cyc(NORM, "post_reset_norm");
   endtask

   task automatic test_load_use();
      ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      cyc(LU, "lu_rs1");
      ex_is_load = 0;
      cyc(NORM, "lu_rs1_resume");
      ex_is_load = 1; ex_rd = 9; id_rs1 = 0; id_rs2 = 9;
      id_use_rs1 = 1; id_use_rs2 = 1;
      cyc(LU, "lu_rs2");
      cyc(NORM, "lu_no_second_bubble");
      idle();
      cyc(NORM, "lu_idle");
   endtask

   task automatic test_no_stall();
      ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      cyc(NORM, "x0_no_stall");
      ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 0;
      cyc(NORM, "unused_rs2");
      idle();
   endtask

   task automatic test_dmem_miss();
      dmem_access = 1; dmem_resp = 0;
      for (int i = 0; i < 4; i++) cyc(FRZ, "dmiss_freeze");
      dmem_resp = 1;
      cyc(NORM, "dmiss_exit");
      idle();
      imem_read = 1; imem_resp = 0;
      cyc(FRZ, "imiss_freeze");
      imem_resp = 1;
      cyc(NORM, "imiss_exit");
      idle();
   endtask

   task automatic test_redirect_in_miss();
      dmem_access = 1; dmem_resp = 0; ex_br_redirect = 1;
      cyc(FRZ, "redir_frozen0");
      ex_br_redirect = 0;
      cyc(FRZ, "redir_frozen1");
      cyc(FRZ, "redir_frozen2");
      dmem_resp = 1;
      cyc(RD, "redir_replay");
      idle();
      cyc(NORM, "redir_after");
   endtask

   task automatic test_back_to_back();
      ex_br_redirect = 1;
      ex_is_load = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
      cyc(RD, "redir_over_lu");
      idle();
      cyc(NORM, "redir_no_lstall");
      ex_is_load = 1; ex_rd = 6; id_rs2 = 6; id_use_rs2 = 1;
      cyc(LU, "lu_then_miss");
      ex_is_load = 0; dmem_access = 1; dmem_resp = 0;
      cyc(FRZ, "lstall_miss");
      dmem_resp = 1;
      cyc(NORM, "lstall_miss_exit");
      idle();
   endtask

   task automatic test_reset_mid_wait();
      dmem_access = 1; dmem_resp = 0; ex_br_redirect = 1;
      cyc(FRZ, "rstw_frz0");
      ex_br_redirect = 0;
      #2;
      rst = 1'b1;
      m_stall = '0;
      m_flush = '0;
      #1;
      nvec++;
      if (ctl() !== 8'h00) begin
         nerr++;
         $display("FAIL async_rst_ctl got %b want %b", ctl(), 8'h00);
      end
      nvec++;
      if ({stall_cycles, flush_count} !== '0) begin
         nerr++;
         $display("FAIL async_rst_cnt got %0d/%0d want 0/0",
                  stall_cycles, flush_count);
      end
      @(negedge clk);
      idle();
      rst = 1'b0;
      cyc(NORM, "rstw_no_replay");
   endtask

   task automatic test_saturation();
      dmem_access = 1; dmem_resp = 0;
      for (int i = 0; i < 36; i++) cyc(FRZ, "sat_stall");
      idle();
      ex_br_redirect = 1;
      for (int i = 0; i < 34; i++) cyc(RD, "sat_flush");
      idle();
      cyc(NORM, "sat_hold");
      nvec++;
      if ({stall_cycles, flush_count} !== {MAXC, MAXC}) begin
         nerr++;
         $display("FAIL sat_final got %0d/%0d want %0d/%0d",
                  stall_cycles, flush_count, MAXC, MAXC);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_dmem_miss();
      test_redirect_in_miss();
      test_back_to_back();
      test_reset_mid_wait();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
